// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: bus widths, size and
// state encodings, timeout default, and alignment/store-format helpers.
package mem_access_ctrl_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int ADDR_WIDTH      = 32;
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Natural alignment: bytes anywhere, halves on even, words on 4-byte.
    function automatic logic is_aligned(input mem_size_e size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = (addr_lo[0] == 1'b0);
            SIZE_WORD: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input mem_size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: begin
                if (addr_lo[1]) begin
                    be = 4'b1100;
                end else begin
                    be = 4'b0011;
                end
            end
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate sub-word store data across every lane so byte enables pick it.
    function automatic logic [WORD_WIDTH-1:0] store_data(input mem_size_e size,
                                                         input logic [WORD_WIDTH-1:0] wdata);
        logic [WORD_WIDTH-1:0] d;
        case (size)
            SIZE_BYTE: d = {4{wdata[7:0]}};
            SIZE_HALF: d = {2{wdata[15:0]}};
            default:   d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load formatter: picks the addressed byte/half out of a DRAM word and
// sign- or zero-extends it to a full word. Purely combinational.
module load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] rdata,
    input  logic [1:0]            addr,
    input  mem_size_e             size,
    input  logic                  sign,
    output logic [WORD_WIDTH-1:0] word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the byte lane addressed by the low address bits.
    always_comb begin
        byte_s = 8'h00;
        case (addr)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Select the half lane; addr[0] is guaranteed zero for legal halves.
    always_comb begin
        half_s = 16'h0000;
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected lane to a full word.
    always_comb begin
        word = '0;
        case (size)
            SIZE_BYTE: word = {{24{sign & byte_s[7]}}, byte_s};
            SIZE_HALF: word = {{16{sign & half_s[15]}}, half_s};
            SIZE_WORD: word = rdata;
            default:   word = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller: turns EX/MEM load/store requests into a
// single held DRAM transaction, stalls the pipeline while it is outstanding,
// formats load data, and flags misaligned accesses and DRAM timeouts.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_mem_re,
    input  logic                  ex_mem_we,
    input  logic [ADDR_WIDTH-1:0] ex_mem_addr,
    input  logic [WORD_WIDTH-1:0] ex_mem_wdata,
    input  logic [1:0]            ex_mem_size,
    input  logic                  ex_mem_sign,
    output logic                  dram_req,
    output logic                  dram_we,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [WORD_WIDTH-1:0] dram_wdata,
    output logic [3:0]            dram_be,
    input  logic [WORD_WIDTH-1:0] dram_rdata,
    input  logic                  dram_ack,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  mem_stall,
    output logic                  mem_misalign,
    output logic                  mem_fault
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                state_r;
    state_e                state_nxt_s;
    mem_size_e             size_s;
    logic                  req_s;
    logic                  legal_s;
    logic                  timeout_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [1:0]            ld_addr_lo_r;
    mem_size_e             ld_size_r;
    logic                  ld_sign_r;
    logic                  ld_is_load_r;
    logic [WORD_WIDTH-1:0] align_word_s;

    assign size_s    = mem_size_e'(ex_mem_size);
    assign req_s     = ex_mem_re | ex_mem_we;
    assign legal_s   = is_aligned(size_s, ex_mem_addr[1:0]);
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    load_align u_load_align (
        .rdata (dram_rdata),
        .addr  (ld_addr_lo_r),
        .size  (ld_size_r),
        .sign  (ld_sign_r),
        .word  (align_word_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an ack in the timeout cycle still counts as success.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s && legal_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dram_ack || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pipeline stall: raised as soon as a legal request shows up, held while busy.
    always_comb begin
        mem_stall = 1'b0;
        case (state_r)
            ST_IDLE: mem_stall = req_s & legal_s;
            ST_BUSY: mem_stall = 1'b1;
            ST_DONE: mem_stall = 1'b0;
            default: mem_stall = 1'b0;
        endcase
    end

    // Registered DRAM command, load result, status pulses and busy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dram_req     <= 1'b0;
            dram_we      <= 1'b0;
            dram_addr    <= '0;
            dram_wdata   <= '0;
            dram_be      <= 4'b0000;
            mem_data     <= '0;
            mem_misalign <= 1'b0;
            mem_fault    <= 1'b0;
            cnt_r        <= '0;
            ld_addr_lo_r <= 2'b00;
            ld_size_r    <= SIZE_BYTE;
            ld_sign_r    <= 1'b0;
            ld_is_load_r <= 1'b0;
        end else begin
            mem_misalign <= 1'b0;
            mem_fault    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s && legal_s) begin
                        // A simultaneous read and write is a store.
                        dram_req     <= 1'b1;
                        dram_we      <= ex_mem_we;
                        dram_addr    <= {ex_mem_addr[ADDR_WIDTH-1:2], 2'b00};
                        dram_wdata   <= store_data(size_s, ex_mem_wdata);
                        dram_be      <= ex_mem_we ? store_be(size_s, ex_mem_addr[1:0]) : 4'b1111;
                        cnt_r        <= '0;
                        ld_addr_lo_r <= ex_mem_addr[1:0];
                        ld_size_r    <= size_s;
                        ld_sign_r    <= ex_mem_sign;
                        ld_is_load_r <= ~ex_mem_we;
                    end else if (req_s) begin
                        mem_misalign <= 1'b1;
                        mem_data     <= '0;
                    end
                end
                ST_BUSY: begin
                    if (dram_ack) begin
                        dram_req <= 1'b0;
                        dram_we  <= 1'b0;
                        if (ld_is_load_r) begin
                            mem_data <= align_word_s;
                        end
                    end else if (timeout_s) begin
                        dram_req  <= 1'b0;
                        dram_we   <= 1'b0;
                        mem_fault <= 1'b1;
                        mem_data  <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver pushes hand-computed
// expected DRAM commands and completions; a negedge monitor pops and compares.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int TO      = 4;
    localparam int K_LOAD  = 0;
    localparam int K_STORE = 1;
    localparam int K_FAULT = 2;
    localparam int K_MIS   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_re, ex_mem_we, ex_mem_sign;
    logic [31:0] ex_mem_addr, ex_mem_wdata;
    logic [1:0]  ex_mem_size;
    logic        dram_req, dram_we, dram_ack;
    logic [31:0] dram_addr, dram_wdata, dram_rdata, mem_data;
    logic [3:0]  dram_be;
    logic        mem_stall, mem_misalign, mem_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          busy;
    } rsp_t;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] rdata;
        int          ack_lat;
        int          kind;
        logic [3:0]  be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    vec_t vecs[13];

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem_re    (ex_mem_re),
        .ex_mem_we    (ex_mem_we),
        .ex_mem_addr  (ex_mem_addr),
        .ex_mem_wdata (ex_mem_wdata),
        .ex_mem_size  (ex_mem_size),
        .ex_mem_sign  (ex_mem_sign),
        .dram_req     (dram_req),
        .dram_we      (dram_we),
        .dram_addr    (dram_addr),
        .dram_wdata   (dram_wdata),
        .dram_be      (dram_be),
        .dram_rdata   (dram_rdata),
        .dram_ack     (dram_ack),
        .mem_data     (mem_data),
        .mem_stall    (mem_stall),
        .mem_misalign (mem_misalign),
        .mem_fault    (mem_fault)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_req();
        ex_mem_re    = 1'b0;
        ex_mem_we    = 1'b0;
        ex_mem_addr  = 32'h0;
        ex_mem_wdata = 32'h0;
        ex_mem_size  = 2'b00;
        ex_mem_sign  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int guard;
        @(posedge clk); #1;
        ex_mem_re    = v.re;
        ex_mem_we    = v.we;
        ex_mem_addr  = v.addr;
        ex_mem_wdata = v.wdata;
        ex_mem_size  = v.size;
        ex_mem_sign  = v.sign;
        dram_rdata   = v.rdata;
        if (v.kind != K_MIS) begin
            req_q.push_back('{v.we, v.exp_addr, v.exp_wdata, v.be});
        end
        rsp_q.push_back('{v.kind, v.exp_data, (v.kind == K_FAULT) ? TO : v.ack_lat + 1});
        @(negedge clk);
        check("stall_request_cycle", {31'h0, mem_stall}, (v.kind != K_MIS) ? 32'h1 : 32'h0);
        @(posedge clk); #1;
        if (v.kind == K_MIS) begin
            clear_req();
            repeat (2) @(posedge clk);
        end else begin
            if (v.ack_lat >= 0) begin
                repeat (v.ack_lat) begin
                    @(posedge clk); #1;
                end
                dram_ack = 1'b1;
                @(posedge clk); #1;
                dram_ack = 1'b0;
            end else begin
                guard = 0;
                while (mem_stall && guard < 64) begin
                    @(posedge clk); #1;
                    guard++;
                end
                check("busy_bounded", {31'h0, mem_stall}, 32'h0);
            end
            clear_req();
        end
    endtask

    // Monitor: checks every DRAM command, busy-length, completion and misalign pulse.
    initial begin
        logic prev_req;
        logic done_evt;
        int   busy_cnt;
        req_t cur;
        rsp_t r;
        logic have_cur;
        prev_req = 1'b0;
        busy_cnt = 0;
        have_cur = 1'b0;
        cur      = '{1'b0, 32'h0, 32'h0, 4'h0};
        forever begin
            @(negedge clk);
            done_evt = 1'b0;
            if (rst) begin
                prev_req = 1'b0;
                have_cur = 1'b0;
                busy_cnt = 0;
            end else begin
                if (dram_req) begin
                    if (!prev_req) begin
                        busy_cnt = 0;
                        if (req_q.size() == 0) begin
                            check("unexpected_dram_req", 32'h1, 32'h0);
                            have_cur = 1'b0;
                        end else begin
                            cur      = req_q.pop_front();
                            have_cur = 1'b1;
                        end
                    end
                    busy_cnt++;
                    if (have_cur) begin
                        check("dram_we",    {31'h0, dram_we}, {31'h0, cur.we});
                        check("dram_addr",  dram_addr, cur.addr);
                        check("dram_wdata", dram_wdata, cur.wdata);
                        check("dram_be",    {28'h0, dram_be}, {28'h0, cur.be});
                        check("stall_busy", {31'h0, mem_stall}, 32'h1);
                    end
                end else if (prev_req) begin
                    done_evt = 1'b1;
                    if (rsp_q.size() == 0) begin
                        check("unexpected_completion", 32'h1, 32'h0);
                    end else begin
                        r = rsp_q.pop_front();
                        check("completion_kind", {31'h0, (r.kind != K_MIS)}, 32'h1);
                        check("mem_data",   mem_data, r.data);
                        check("mem_fault",  {31'h0, mem_fault}, (r.kind == K_FAULT) ? 32'h1 : 32'h0);
                        check("busy_cycles", busy_cnt, r.busy);
                        check("stall_done", {31'h0, mem_stall}, 32'h0);
                    end
                end
                if (mem_misalign) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_misalign", 32'h1, 32'h0);
                    end else begin
                        r = rsp_q.pop_front();
                        check("misalign_kind", r.kind, K_MIS);
                        check("misalign_data", mem_data, 32'h0);
                        check("misalign_req",  {31'h0, dram_req}, 32'h0);
                        check("misalign_stall", {31'h0, mem_stall}, 32'h0);
                    end
                end
                if (!done_evt) begin
                    check("fault_outside_done", {31'h0, mem_fault}, 32'h0);
                end
                prev_req = dram_req;
            end
        end
    end

    // Stimulus: reset, directed vector table, reset during BUSY, final access.
    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 0,  K_LOAD,  4'hF, 32'h100, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 32'h103, 32'h0,        2'b00, 1'b1, 32'h80112233, 0,  K_LOAD,  4'hF, 32'h100, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 32'h103, 32'h0,        2'b00, 1'b0, 32'h80112233, 1,  K_LOAD,  4'hF, 32'h100, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b0, 1'b1, 32'h202, 32'h0000ABCD, 2'b01, 1'b0, 32'h0,        2,  K_STORE, 4'hC, 32'h200, 32'hABCDABCD, 32'h00000080};
        vecs[4]  = '{1'b1, 1'b0, 32'h101, 32'h0,        2'b10, 1'b0, 32'h0,        0,  K_MIS,   4'h0, 32'h0,   32'h0,        32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h206, 32'h0,        2'b01, 1'b1, 32'h80017FFF, 1,  K_LOAD,  4'hF, 32'h204, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{1'b0, 1'b1, 32'h311, 32'h123456A5, 2'b00, 1'b0, 32'h0,        0,  K_STORE, 4'h2, 32'h310, 32'hA5A5A5A5, 32'hFFFF8001};
        vecs[7]  = '{1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 2'b10, 1'b0, 32'h5555AAAA, 0,  K_STORE, 4'hF, 32'h400, 32'hCAFEF00D, 32'hFFFF8001};
        vecs[8]  = '{1'b1, 1'b0, 32'h500, 32'h0,        2'b10, 1'b0, 32'h12345678, -1, K_FAULT, 4'hF, 32'h500, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h003, 32'h00001111, 2'b01, 1'b0, 32'h0,        0,  K_MIS,   4'h0, 32'h0,   32'h0,        32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h600, 32'h0,        2'b11, 1'b0, 32'h0,        0,  K_MIS,   4'h0, 32'h0,   32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h000, 32'h0,        2'b01, 1'b0, 32'h1234F00D, 0,  K_LOAD,  4'hF, 32'h000, 32'h0,        32'h0000F00D};
        vecs[12] = '{1'b1, 1'b0, 32'h102, 32'h0,        2'b00, 1'b1, 32'h00700000, 3,  K_LOAD,  4'hF, 32'h100, 32'h0,        32'h00000070};

        rst        = 1'b1;
        dram_ack   = 1'b0;
        dram_rdata = 32'h0;
        clear_req();
        repeat (2) @(negedge clk);
        check("rst_dram_req",  {31'h0, dram_req}, 32'h0);
        check("rst_dram_be",   {28'h0, dram_be}, 32'h0);
        check("rst_mem_data",  mem_data, 32'h0);
        check("rst_mem_stall", {31'h0, mem_stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the second BUSY cycle of a load, followed by a stray ack.
        @(posedge clk); #1;
        ex_mem_re   = 1'b1;
        ex_mem_addr = 32'h100;
        ex_mem_size = 2'b10;
        dram_rdata  = 32'h11223344;
        req_q.push_back('{1'b0, 32'h100, 32'h0, 4'hF});
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", {31'h0, dram_req}, 32'h1);
        rst = 1'b1;
        clear_req();
        #1;
        check("rst_busy_req",   {31'h0, dram_req}, 32'h0);
        check("rst_busy_data",  mem_data, 32'h0);
        check("rst_busy_addr",  dram_addr, 32'h0);
        check("rst_busy_stall", {31'h0, mem_stall}, 32'h0);
        @(posedge clk); #1;
        rst      = 1'b0;
        dram_ack = 1'b1;
        @(posedge clk); #1;
        dram_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req",   {31'h0, dram_req}, 32'h0);
        check("late_ack_data",  mem_data, 32'h0);
        check("late_ack_stall", {31'h0, mem_stall}, 32'h0);

        run_vec(vecs[12]);

        repeat (3) @(posedge clk);
        check("req_q_empty", req_q.size(), 32'h0);
        check("rsp_q_empty", rsp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
